// File: rtl/mem_access_pkg.sv
// Shared op/state encodings and decode helpers for the load/store front-end.
package mem_access_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] ofs);
        logic r;
        case (op)
            OP_LW, OP_SW:         r = (ofs != 2'b00);
            OP_LH, OP_LHU, OP_SH: r = ofs[0];
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_load(input logic [2:0] op);
        return (op <= OP_LBU);
    endfunction

    function automatic logic is_rmw_store(input logic [2:0] op);
        return (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Byte-lane datapath: load extract/extend and store merge, purely combinational.
module mau_lane
    import mem_access_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_ofs,
    input  logic [31:0] i_load_word,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_merged
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane of the read word and extend it to a full word.
    always_comb begin
        w_byte = i_load_word[{i_ofs, 3'b000} +: 8];
        if (i_ofs[1]) begin
            w_half = i_load_word[31:16];
        end else begin
            w_half = i_load_word[15:0];
        end
        case (i_op)
            OP_LW:   o_rdata = i_load_word;
            OP_LH:   o_rdata = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_rdata = {16'h0000, w_half};
            OP_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_rdata = {24'h000000, w_byte};
            default: o_rdata = 32'h0000_0000;
        endcase
    end

    // Overlay the store data onto the previously read word.
    always_comb begin
        o_merged = i_old_word;
        case (i_op)
            OP_SW: o_merged = i_wdata;
            OP_SH: begin
                if (i_ofs[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0] = i_wdata[15:0];
                end
            end
            OP_SB:   o_merged[{i_ofs, 3'b000} +: 8] = i_wdata[7:0];
            default: o_merged = i_old_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: request capture, IDLE/RD/WR/RESP sequencing and
// memory port driving for a word-addressed, combinationally read memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 10
)
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [M+1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic [M-1:0] mem_addr,
    output logic [N-1:0] mem_in,
    output logic         mem_we,
    input  logic [N-1:0] mem_out
);
    state_t       r_state;
    state_t       w_next;
    logic [2:0]   r_op;
    logic [M+1:0] r_addr;
    logic [N-1:0] r_wdata;
    logic [N-1:0] r_rdata;
    logic [N-1:0] r_rsp_rdata;
    logic         r_err;
    logic         w_accept;
    logic         w_misaligned;
    logic [N-1:0] w_load_val;
    logic [N-1:0] w_merged;

    assign w_accept     = req_valid && (r_state == ST_IDLE);
    assign w_misaligned = is_misaligned(req_op, req_addr[1:0]);

    mau_lane u_lane (
        .i_op        (r_op),
        .i_ofs       (r_addr[1:0]),
        .i_load_word (mem_out),
        .i_old_word  (r_rdata),
        .i_wdata     (r_wdata),
        .o_rdata     (w_load_val),
        .o_merged    (w_merged)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; misaligned requests skip memory entirely.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_accept) begin
                    w_next = ST_IDLE;
                end else if (w_misaligned) begin
                    w_next = ST_RESP;
                end else if (req_op == OP_SW) begin
                    w_next = ST_WR;
                end else begin
                    w_next = ST_RD;
                end
            end
            ST_RD: begin
                if (is_rmw_store(r_op)) begin
                    w_next = ST_WR;
                end else begin
                    w_next = ST_RESP;
                end
            end
            ST_WR:   w_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture, read-word capture and response registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op        <= 3'd0;
            r_addr      <= {(M+2){1'b0}};
            r_wdata     <= {N{1'b0}};
            r_rdata     <= {N{1'b0}};
            r_rsp_rdata <= {N{1'b0}};
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= req_op;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_err       <= w_misaligned;
                        r_rsp_rdata <= {N{1'b0}};
                    end
                end
                ST_RD: begin
                    r_rdata <= mem_out;
                    if (is_load(r_op)) begin
                        r_rsp_rdata <= w_load_val;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_err       <= 1'b0;
                        r_rsp_rdata <= {N{1'b0}};
                    end
                end
                default: begin
                    r_err <= r_err;
                end
            endcase
        end
    end

    // Write enable is a pure state decode so reset removes it without waiting for a clock.
    assign mem_we    = (r_state == ST_WR);
    assign mem_in    = mem_we ? w_merged : {N{1'b0}};
    assign mem_addr  = r_addr[M+1:2];
    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_err;

endmodule
